anc_tap_sequencer: RTL and testbench
====================================

Name: anc_tap_sequencer

Overview:
- Upstream feeder of the ANC FIR filter stage.
- Stores the last TAPS reference samples in a circular delay line, plus a TAPS-entry weight register file.
- On each new sample, runs one filter frame: a Synch/clear window, then one FilterEN pulse per tap presenting the matching sample/weight pair, then a done pulse.
- Sits between the ADC/sample front end, the weight-update (LMS) block and the filter stage.

Parameters:
- TAPS, 32, number of filter taps; must be a power of two, at least 2.
- DW, 11, sample and weight width, two's complement.
- AW, 5, log2(TAPS); index width.

Ports:
- Clk_100M  in  1  system clock, all logic on rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- Sample_In  in  DW  new reference sample.
- Sample_Valid  in  1  one-cycle strobe; Sample_In valid this cycle.
- Wz_Wr_En  in  1  weight write strobe.
- Wz_Wr_Addr  in  AW  weight index to write.
- Wz_Wr_Data  in  DW  weight value.
- Sig_Out  out  DW  delayed sample for the current tap; drives the filter's Sig_In.
- Wz_Out  out  DW  weight for the current tap; drives the filter's Wz_In.
- FilterEN_Out  out  1  per-tap enable; drives the filter's FilterEN_In.
- Synch_Out  out  1  frame-start accumulator clear; drives the filter's Synch_In.
- Tap_Idx  out  AW  index of the tap currently presented.
- Busy  out  1  frame in progress.
- Frame_Done  out  1  one-cycle pulse after the last tap.
- Overrun  out  1  sticky flag: a sample arrived while Busy.

Behaviour:
- Reset (Reset_N low, async):
  - All outputs 0; FSM to IDLE.
  - Write pointer 0; all delay-line and weight entries 0; Overrun 0.
- All outputs are registered.
- FSM states: IDLE, SYNC0, SYNC1, TAP_EN, TAP_GAP, DONE.
- IDLE:
  - Sample_Valid=1: write Sample_In at wr_ptr, go to SYNC0.
  - Busy goes high the next cycle.
- SYNC0, SYNC1:
  - Synch_Out=1, FilterEN_Out=0, for 2 cycles.
  - The filter clears its accumulator during this window.
  - Tap counter k cleared to 0.
  - SYNC0 -> SYNC1 -> TAP_EN.
- TAP_EN:
  - FilterEN_Out=1, Synch_Out=0, Tap_Idx=k.
  - Sig_Out = line[(wr_ptr - k) mod TAPS], where tap 0 is the newest sample.
  - Wz_Out = W[k].
  - Sig_Out and Wz_Out are stable for the entire high phase and the following gap cycle.
  - Next state TAP_GAP.
- TAP_GAP:
  - FilterEN_Out=0; the falling edge lets the filter latch its partial sum.
  - If k = TAPS-1, go to DONE; otherwise k <= k+1 and go to TAP_EN.
- DONE:
  - Frame_Done=1 for 1 cycle.
  - wr_ptr <= wr_ptr+1, wrapping TAPS-1 -> 0.
  - Busy=0 from the next cycle; go to IDLE.
- Timing, with the Sample_Valid accept edge as cycle 0:
  - Synch_Out high in cycles 1-2.
  - Tap k enable in cycle 3+2k.
  - Frame_Done in cycle 3+2*TAPS, i.e. cycle 67 at default.
  - Minimum sample period is 4+2*TAPS cycles.
- Sample_Valid while Busy or in DONE:
  - Sample dropped; delay line and pointer unchanged.
  - Overrun set; cleared only by reset.
- Sample_Valid in the same cycle that DONE returns to IDLE: dropped (counts as Busy).
- Weight writes:
  - Accepted in any state.
  - Take effect on the next edge.
  - A write to W[k] in the same cycle W[k] is read returns the old value for that tap.
  - Weights written mid-frame to taps not yet read are used in that frame.
- Pointer wrap: reading (wr_ptr - k) uses modulo-TAPS unsigned subtraction; no sign or saturation handling, it is pure indexing.
- Data passes through unmodified: no arithmetic on samples or weights; width DW preserved.
- Reset mid-frame: immediate abort. FilterEN_Out and Synch_Out drop asynchronously to 0; no Frame_Done.

Decomposition:
- Package anc_pkg holds:
  - DW, TAPS, AW defaults.
  - FSM state encoding (typedef enum).
  - SYNC_CYCLES=2 constant.
- Sub-module anc_delay_line:
  - TAPS x DW circular register buffer.
  - Write port plus wr_ptr.
  - Combinational read at offset k.
  - Async active-low clear.
- The weight file stays inline in the top; it is a plain register array.

Test Plan:
- Reset, then write W[k]=k+1 for all k; feed samples 1, 2, 3 at 70-cycle spacing.
  -> Third frame, tap 0: Sig_Out=3, Wz_Out=1. Tap 1: Sig_Out=2, Wz_Out=2. Tap 2: Sig_Out=1. Taps 3..31: Sig_Out=0.
- Single sample -> Synch_Out high cycles 1-2; FilterEN_Out high on cycles 3, 5, ..., 65; Frame_Done on cycle 67; Busy low on cycle 68.
- Feed 33 samples of value s=n (1..33), then one more frame.
  -> Verifies wrap: tap 0 = 33, tap 31 = 2; no value 1 visible.
- Sample_Valid at cycle 10 of a frame -> Overrun=1; frame unaffected; the next frame's tap 0 is still the previous sample.
- Weight write W[5]=-7 (11'h7F9) issued the same cycle tap 5 is enabled -> Wz_Out shows the old W[5]; the next frame shows 11'h7F9.
- Assert Reset_N low at cycle 20 of a frame -> all outputs 0 asynchronously; Overrun 0. After release, a new sample starts a clean frame with all other taps 0.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared defaults and FSM encoding for the ANC tap sequencer slice.
package anc_pkg;
  localparam int ANC_TAPS    = 32;
  localparam int ANC_DW      = 11;
  localparam int ANC_AW      = 5;
  localparam int SYNC_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC0,
    SYNC1,
    TAP_EN,
    TAP_GAP,
    DONE
  } state_e;
endpackage

// File: rtl/anc_delay_line.sv
// Circular TAPS x DW reference-sample buffer; read at a tap offset behind the write pointer.
module anc_delay_line
  import anc_pkg::*;
#(
  parameter int TAPS = ANC_TAPS,
  parameter int DW   = ANC_DW,
  parameter int AW   = ANC_AW
) (
  input  logic          Clk_100M,
  input  logic          Reset_N,
  input  logic          Wr_En,
  input  logic [AW-1:0] Wr_Ptr,
  input  logic [DW-1:0] Wr_Data,
  input  logic [AW-1:0] Rd_Off,
  output logic [DW-1:0] Rd_Data
);
  logic [DW-1:0] line [TAPS];
  logic [AW-1:0] rdIdx;

  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
    end else if (Wr_En) begin
      line[Wr_Ptr] <= Wr_Data;
    end
  end

  // AW-bit subtraction wraps modulo TAPS; tap 0 is the newest sample.
  assign rdIdx   = Wr_Ptr - Rd_Off;
  assign Rd_Data = line[rdIdx];
endmodule

// File: rtl/anc_tap_sequencer.sv
// Per-sample frame sequencer feeding sample/weight pairs, one per tap, to the ANC FIR stage.
module anc_tap_sequencer
  import anc_pkg::*;
#(
  parameter int TAPS = ANC_TAPS,
  parameter int DW   = ANC_DW,
  parameter int AW   = ANC_AW
) (
  input  logic          Clk_100M,
  input  logic          Reset_N,
  input  logic [DW-1:0] Sample_In,
  input  logic          Sample_Valid,
  input  logic          Wz_Wr_En,
  input  logic [AW-1:0] Wz_Wr_Addr,
  input  logic [DW-1:0] Wz_Wr_Data,
  output logic [DW-1:0] Sig_Out,
  output logic [DW-1:0] Wz_Out,
  output logic          FilterEN_Out,
  output logic          Synch_Out,
  output logic [AW-1:0] Tap_Idx,
  output logic          Busy,
  output logic          Frame_Done,
  output logic          Overrun
);
  state_e        state, nxtState;
  logic [AW-1:0] wrPtr, tapK;
  logic [DW-1:0] lineRd;
  logic [DW-1:0] wz [TAPS];
  logic          accept, lastTap;
  logic          synchD, enD, doneD, busyD;

  assign accept  = Sample_Valid && (state == IDLE);
  assign lastTap = (tapK == AW'(TAPS - 1));

  anc_delay_line #(.TAPS(TAPS), .DW(DW), .AW(AW)) uLine (
    .Clk_100M (Clk_100M),
    .Reset_N  (Reset_N),
    .Wr_En    (accept),
    .Wr_Ptr   (wrPtr),
    .Wr_Data  (Sample_In),
    .Rd_Off   (tapK),
    .Rd_Data  (lineRd)
  );

  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) state <= IDLE;
    else          state <= nxtState;
  end

  // Output strobes are decoded from the current state and registered one edge later.
  always_comb begin
    nxtState = state;
    synchD   = 1'b0;
    enD      = 1'b0;
    doneD    = 1'b0;
    busyD    = (state != IDLE);
    unique case (state)
      IDLE:    if (Sample_Valid) nxtState = SYNC0;
      SYNC0:   begin synchD = 1'b1; nxtState = SYNC1;  end
      SYNC1:   begin synchD = 1'b1; nxtState = TAP_EN; end
      TAP_EN:  begin enD = 1'b1;    nxtState = TAP_GAP; end
      TAP_GAP: nxtState = lastTap ? DONE : TAP_EN;
      DONE:    begin doneD = 1'b1;  nxtState = IDLE;   end
      default: nxtState = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      tapK  <= '0;
      wrPtr <= '0;
    end else begin
      if (state == SYNC0 || state == SYNC1)  tapK <= '0;
      else if (state == TAP_GAP && !lastTap) tapK <= tapK + 1'b1;
      if (state == DONE) wrPtr <= wrPtr + 1'b1;
    end
  end

  // Write lands on the edge it is sampled, so a same-edge read of that tap sees the old weight.
  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < TAPS; i++) wz[i] <= '0;
    end else if (Wz_Wr_En) begin
      wz[Wz_Wr_Addr] <= Wz_Wr_Data;
    end
  end

  always_ff @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      Synch_Out    <= 1'b0;
      FilterEN_Out <= 1'b0;
      Frame_Done   <= 1'b0;
      Busy         <= 1'b0;
      Overrun      <= 1'b0;
      Sig_Out      <= '0;
      Wz_Out       <= '0;
      Tap_Idx      <= '0;
    end else begin
      Synch_Out    <= synchD;
      FilterEN_Out <= enD;
      Frame_Done   <= doneD;
      Busy         <= busyD;
      if (Sample_Valid && state != IDLE) Overrun <= 1'b1;
      // Pair is captured on the enable edge and held through the following gap.
      if (state == TAP_EN) begin
        Sig_Out <= lineRd;
        Wz_Out  <= wz[tapK];
        Tap_Idx <= tapK;
      end
    end
  end
endmodule

// File: tb/tb_anc_tap_sequencer.sv
// Randomised bench for anc_tap_sequencer against a cycle-arithmetic frame model.
module tb_anc_tap_sequencer;
  localparam int TAPS = 32;
  localparam int DW   = 11;
  localparam int AW   = 5;
  localparam int FLEN = 3 + 2 * TAPS;

  logic          Clk_100M = 1'b0;
  logic          Reset_N = 1'b0;
  logic [DW-1:0] Sample_In = '0;
  logic          Sample_Valid = 1'b0;
  logic          Wz_Wr_En = 1'b0;
  logic [AW-1:0] Wz_Wr_Addr = '0;
  logic [DW-1:0] Wz_Wr_Data = '0;
  logic [DW-1:0] Sig_Out, Wz_Out;
  logic          FilterEN_Out, Synch_Out, Busy, Frame_Done, Overrun;
  logic [AW-1:0] Tap_Idx;

  always #5 Clk_100M = ~Clk_100M;

  anc_tap_sequencer dut (
    .Clk_100M     (Clk_100M),
    .Reset_N      (Reset_N),
    .Sample_In    (Sample_In),
    .Sample_Valid (Sample_Valid),
    .Wz_Wr_En     (Wz_Wr_En),
    .Wz_Wr_Addr   (Wz_Wr_Addr),
    .Wz_Wr_Data   (Wz_Wr_Data),
    .Sig_Out      (Sig_Out),
    .Wz_Out       (Wz_Out),
    .FilterEN_Out (FilterEN_Out),
    .Synch_Out    (Synch_Out),
    .Tap_Idx      (Tap_Idx),
    .Busy         (Busy),
    .Frame_Done   (Frame_Done),
    .Overrun      (Overrun)
  );

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nChk++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Model: newest-first sample history, weight copy, frame start edge number.
  int            cyc = 0;
  int            fs = -1;
  int            md;
  logic [DW-1:0] hist [TAPS];
  logic [DW-1:0] mw [TAPS];
  bit            eSynch, eEn, eDone, eBusy, eOv, tapWin;
  int            eSig, eWz, eIdx;

  always @(posedge Clk_100M or negedge Reset_N) begin
    if (!Reset_N) begin
      fs = -1;
      {eSynch, eEn, eDone, eBusy, eOv, tapWin} = '0;
      eSig = 0; eWz = 0; eIdx = 0;
      for (int i = 0; i < TAPS; i++) begin hist[i] = '0; mw[i] = '0; end
    end else begin
      cyc++;
      md     = (fs < 0) ? -1 : cyc - fs;
      eSynch = (md == 1 || md == 2);
      eEn    = (md >= 3 && md <= FLEN - 2 && md % 2 == 1);
      eDone  = (md == FLEN);
      eBusy  = (md >= 1 && md <= FLEN);
      tapWin = (md >= 3 && md <= FLEN - 1);
      if (eEn) begin
        eIdx = (md - 3) / 2;
        eSig = int'(hist[eIdx]);
        eWz  = int'(mw[eIdx]);
      end
      if (Sample_Valid) begin
        if (fs < 0 || md >= FLEN + 1) begin
          for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = Sample_In;
          fs = cyc;
        end else eOv = 1'b1;
      end
      if (Wz_Wr_En) mw[Wz_Wr_Addr] = Wz_Wr_Data;
    end
  end

  always @(negedge Clk_100M) begin
    if (Reset_N) begin
      chk("Synch_Out", int'(Synch_Out), int'(eSynch));
      chk("FilterEN_Out", int'(FilterEN_Out), int'(eEn));
      chk("Frame_Done", int'(Frame_Done), int'(eDone));
      chk("Busy", int'(Busy), int'(eBusy));
      chk("Overrun", int'(Overrun), int'(eOv));
      if (tapWin) begin
        chk("Sig_Out", int'(Sig_Out), eSig);
        chk("Wz_Out", int'(Wz_Out), eWz);
        chk("Tap_Idx", int'(Tap_Idx), eIdx);
      end
    end
  end

  // Per-frame capture for the literal checks.
  logic [DW-1:0] gSig [TAPS];
  logic [DW-1:0] gWz  [TAPS];
  bit rSy [0:70];
  bit rEn [0:70];
  bit rDn [0:70];
  bit rBy [0:70];

  task automatic chk_all_zero(input string nm);
    chk({nm, "_synch"}, int'(Synch_Out), 0);
    chk({nm, "_en"}, int'(FilterEN_Out), 0);
    chk({nm, "_done"}, int'(Frame_Done), 0);
    chk({nm, "_busy"}, int'(Busy), 0);
    chk({nm, "_ovr"}, int'(Overrun), 0);
    chk({nm, "_sig"}, int'(Sig_Out), 0);
    chk({nm, "_wz"}, int'(Wz_Out), 0);
    chk({nm, "_idx"}, int'(Tap_Idx), 0);
  endtask

  task automatic run_frame(input logic [DW-1:0] v, input int len, input int ovAt,
                           input int wAt, input logic [AW-1:0] wA, input logic [DW-1:0] wD,
                           input int rstAt);
    Sample_Valid = 1'b1;
    Sample_In    = v;
    @(posedge Clk_100M); #1;
    for (int d = 1; d <= len; d++) begin
      Sample_Valid = (d == ovAt);
      Sample_In    = (d == ovAt) ? 11'h155 : '0;
      Wz_Wr_En     = (d == wAt);
      Wz_Wr_Addr   = wA;
      Wz_Wr_Data   = wD;
      @(posedge Clk_100M); #1;
      Sample_Valid = 1'b0;
      Wz_Wr_En     = 1'b0;
      rSy[d] = Synch_Out; rEn[d] = FilterEN_Out; rDn[d] = Frame_Done; rBy[d] = Busy;
      if (d >= 3 && d <= FLEN - 2 && d % 2 == 1) begin
        gSig[(d-3)/2] = Sig_Out;
        gWz[(d-3)/2]  = Wz_Out;
      end
      if (d == rstAt) begin
        Reset_N = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge Clk_100M);
        #1 Reset_N = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int enCnt;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge Clk_100M);
    #1 Reset_N = 1'b1;

    for (int k = 0; k < TAPS; k++) begin
      Wz_Wr_En = 1'b1; Wz_Wr_Addr = AW'(k); Wz_Wr_Data = DW'(k + 1);
      @(posedge Clk_100M); #1;
    end
    Wz_Wr_En = 1'b0;

    run_frame(11'd1, 70, -1, -1, '0, '0, -1);
    chk("t_synch1", int'(rSy[1]), 1);
    chk("t_synch2", int'(rSy[2]), 1);
    chk("t_synch3", int'(rSy[3]), 0);
    chk("t_en3", int'(rEn[3]), 1);
    chk("t_en4", int'(rEn[4]), 0);
    chk("t_en65", int'(rEn[65]), 1);
    chk("t_done66", int'(rDn[66]), 0);
    chk("t_done67", int'(rDn[67]), 1);
    chk("t_busy1", int'(rBy[1]), 1);
    chk("t_busy67", int'(rBy[67]), 1);
    chk("t_busy68", int'(rBy[68]), 0);
    enCnt = 0;
    for (int d = 1; d <= 70; d++) enCnt += int'(rEn[d]);
    chk("t_en_count", enCnt, 32);

    run_frame(11'd2, 70, -1, -1, '0, '0, -1);
    run_frame(11'd3, 70, -1, -1, '0, '0, -1);
    chk("f3_sig0", int'(gSig[0]), 3);
    chk("f3_wz0", int'(gWz[0]), 1);
    chk("f3_sig1", int'(gSig[1]), 2);
    chk("f3_wz1", int'(gWz[1]), 2);
    chk("f3_sig2", int'(gSig[2]), 1);
    chk("f3_sig3", int'(gSig[3]), 0);
    chk("f3_sig31", int'(gSig[31]), 0);

    // Overrun at cycle 10, then a weight write on the tap-5 enable edge.
    run_frame(11'd4, 70, 10, -1, '0, '0, -1);
    chk("ovr_set", int'(Overrun), 1);
    run_frame(11'd5, 70, -1, 13, 5'd5, 11'h7F9, -1);
    chk("ovr_sig0", int'(gSig[0]), 5);
    chk("ovr_sig1", int'(gSig[1]), 4);
    chk("wz5_old", int'(gWz[5]), 6);
    run_frame(11'd6, 70, -1, -1, '0, '0, -1);
    chk("wz5_new", int'(gWz[5]), 'h7F9);

    run_frame(11'd7, 70, -1, -1, '0, '0, 20);
    chk("rst_ovr", int'(Overrun), 0);
    run_frame(11'd8, 70, -1, -1, '0, '0, -1);
    chk("clean_sig0", int'(gSig[0]), 8);
    chk("clean_sig1", int'(gSig[1]), 0);
    chk("clean_wz0", int'(gWz[0]), 0);

    // Wrap: frame for the 33rd sample shows 33 down to 2.
    for (int n = 2; n <= 33; n++) run_frame(DW'(n), 70, -1, -1, '0, '0, -1);
    chk("wrap_sig0", int'(gSig[0]), 33);
    chk("wrap_sig31", int'(gSig[31]), 2);
    for (int k = 0; k < TAPS; k++) chk("wrap_no1", int'(gSig[k] == 11'd1), 0);

    // Random samples, weight writes and stray strobes, including back-to-back frames.
    for (int r = 0; r < 12; r++) begin
      int len, ov;
      len = ($urandom_range(0, 1) == 1) ? 67 : 70;
      ov  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 67) : -1;
      run_frame(DW'($urandom), len, ov, $urandom_range(1, len), AW'($urandom), DW'($urandom), -1);
    end
    repeat (4) @(posedge Clk_100M);
    #1;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
